// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider.
// One trial subtraction per cycle; start pulse in, done pulse out.
module seq_restoring_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [N:0]    r;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] count;

  logic [N:0]    rs;
  logic [N-1:0]  qs;
  logic [N:0]    t;
  logic [N:0]    r_nxt;
  logic [N-1:0]  q_nxt;

  // Subtract as B + ~A + 1 on the shared N+1-bit datapath.
  always_comb begin
    rs    = {r[N-1:0], q[N-1]};
    qs    = {q[N-2:0], 1'b0};
    t     = rs + ~{1'b0, d} + {{N{1'b0}}, 1'b1};
    r_nxt = t[N] ? rs : t;
    q_nxt = t[N] ? qs : {qs[N-1:1], 1'b1};
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              d     <= divisor;
              q     <= dividend;
              r     <= '0;
              count <= CW'(N - 1);
              state <= S_RUN;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r     <= r_nxt;
          q     <= q_nxt;
          count <= count - {{(CW-1){1'b0}}, 1'b1};
          if (count == '0) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt[N-1:0];
            div_by_zero <= 1'b0;
            state       <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and swept checks for seq_restoring_divider.
// Each task drives one scenario and compares inline.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  seq_restoring_divider #(.N(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse start for one edge, then count cycles until done.
  // lat=1 means done is seen in the first cycle after acceptance.
  task automatic run_div(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] qo,
    output logic [7:0] ro,
    output logic       zo,
    output int         lat,
    output int         bcnt
  );
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      bcnt += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    qo = quotient;
    ro = remainder;
    zo = div_by_zero;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset: got q=%0d r=%0d b=%b d=%b z=%b want zeros",
               quotient, remainder, busy, done, div_by_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] qo, ro;
    logic zo;
    int lat, bc;
    run_div(8'd100, 8'd7, qo, ro, zo, lat, bc);
    n_cmp++;
    if (lat !== 9 || bc !== 8) begin
      n_bad++;
      $display("FAIL t1_timing: got lat=%0d busy=%0d want 9/8", lat, bc);
    end
    n_cmp++;
    if (qo !== 8'd14 || ro !== 8'd2 || zo !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_result: got %0d r%0d z%b want 14 r2 z0", qo, ro, zo);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_pulse: got done=%b busy=%b want 0/0", done, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (quotient !== 8'd14 || remainder !== 8'd2) begin
      n_bad++;
      $display("FAIL t1_hold: got %0d r%0d want 14 r2", quotient, remainder);
    end
  endtask

  task automatic test_edges();
    logic [7:0] qo, ro;
    logic zo;
    int lat, bc;
    run_div(8'd255, 8'd1, qo, ro, zo, lat, bc);
    n_cmp++;
    if (qo !== 8'd255 || ro !== 8'd0 || lat !== 9) begin
      n_bad++;
      $display("FAIL t2_255_1: got %0d r%0d lat%0d want 255 r0 lat9", qo, ro, lat);
    end
    run_div(8'd5, 8'd9, qo, ro, zo, lat, bc);
    n_cmp++;
    if (qo !== 8'd0 || ro !== 8'd5) begin
      n_bad++;
      $display("FAIL t2_5_9: got %0d r%0d want 0 r5", qo, ro);
    end
    run_div(8'd0, 8'd3, qo, ro, zo, lat, bc);
    n_cmp++;
    if (qo !== 8'd0 || ro !== 8'd0) begin
      n_bad++;
      $display("FAIL t2_0_3: got %0d r%0d want 0 r0", qo, ro);
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] qo, ro;
    logic zo;
    int lat, bc;
    run_div(8'd42, 8'd0, qo, ro, zo, lat, bc);
    n_cmp++;
    if (lat !== 1 || bc !== 0) begin
      n_bad++;
      $display("FAIL t3_timing: got lat=%0d busy=%0d want 1/0", lat, bc);
    end
    n_cmp++;
    if (qo !== 8'hFF || ro !== 8'd42 || zo !== 1'b1) begin
      n_bad++;
      $display("FAIL t3_result: got %0h r%0d z%b want ff r42 z1", qo, ro, zo);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(posedge clk); #1;
    dividend = 8'd200;
    divisor  = 8'd13;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (3) begin
      @(posedge clk); #1;
      lat++;
    end
    dividend = 8'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== 9) begin
      n_bad++;
      $display("FAIL t4_timing: got lat=%0d want 9", lat);
    end
    n_cmp++;
    if (quotient !== 8'd15 || remainder !== 8'd5 || div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL t4_result: got %0d r%0d z%b want 15 r5 z0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] qo, ro;
    logic zo;
    int lat, bc, seen;
    @(posedge clk); #1;
    dividend = 8'd77;
    divisor  = 8'd4;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      n_bad++;
      $display("FAIL t5_async: got q=%0d r=%0d b=%b d=%b z=%b want zeros",
               quotient, remainder, busy, done, div_by_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      seen += int'(done) + int'(busy);
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL t5_abandon: got %0d done/busy cycles want 0", seen);
    end
    run_div(8'd77, 8'd4, qo, ro, zo, lat, bc);
    n_cmp++;
    if (qo !== 8'd19 || ro !== 8'd1 || lat !== 9) begin
      n_bad++;
      $display("FAIL t5_fresh: got %0d r%0d lat%0d want 19 r1 lat9", qo, ro, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    int last_done, w, bad_inv, bad_gap, bad_wid;
    bad_inv = 0;
    bad_gap = 0;
    bad_wid = 0;
    last_done = -1;
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      w = 0;
      while (!done && w < 40) begin
        @(posedge clk); #1;
        w++;
      end
      if (!done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL t6_timeout: iter %0d no done", i);
        break;
      end
      if (last_done >= 0 && cyc - last_done != 10) bad_gap++;
      last_done = cyc;
      if (16'(quotient) * 16'(b) + 16'(remainder) != 16'(a) ||
          remainder >= b || div_by_zero !== 1'b0) begin
        bad_inv++;
        if (bad_inv < 5)
          $display("FAIL t6_inv: %0d/%0d got %0d r%0d", a, b, quotient, remainder);
      end
      @(posedge clk); #1;
      if (done !== 1'b0) bad_wid++;
    end
    n_cmp++;
    if (bad_inv !== 0) begin
      n_bad++;
      $display("FAIL t6_invariant: got %0d bad want 0", bad_inv);
    end
    n_cmp++;
    if (bad_gap !== 0) begin
      n_bad++;
      $display("FAIL t6_spacing: got %0d bad gaps want 0", bad_gap);
    end
    n_cmp++;
    if (bad_wid !== 0) begin
      n_bad++;
      $display("FAIL t6_width: got %0d wide pulses want 0", bad_wid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
